// File: rtl/dmem_wbuf_pkg.sv
// Shared memory-side types for the data-memory write buffer: the queued store
// entry and the word-address boundary used for merge and hazard matching.
package dmem_wbuf_pkg;

   localparam int WB_ADDR_W     = 32;
   localparam int WB_DATA_W     = 32;
   localparam int WB_STRB_W     = WB_DATA_W / 8;
   localparam int WORD_ADDR_LSB = 2;
   localparam int WORD_W        = WB_ADDR_W - WORD_ADDR_LSB;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic [WB_STRB_W-1:0] strb;
   } wbuf_entry_t;

   // Overlay the strobed bytes of new_data onto old_data.
   function automatic logic [WB_DATA_W-1:0] merge_bytes(
      input logic [WB_DATA_W-1:0] old_data,
      input logic [WB_DATA_W-1:0] new_data,
      input logic [WB_STRB_W-1:0] strb
   );
      logic [WB_DATA_W-1:0] res;
      res = old_data;
      for (int b = 0; b < WB_STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Circular store queue with push, pop and tail-merge ports, plus a per-slot
// word-address match vector covering only occupied slots.
module dmem_wbuf_fifo
   import dmem_wbuf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              merge,
   input  wbuf_entry_t       wr_entry,
   input  logic [WORD_W-1:0] match_word,
   output wbuf_entry_t       head,
   output logic [WORD_W-1:0] tail_word,
   output logic [CNT_W-1:0]  count,
   output logic [DEPTH-1:0]  match
);

   localparam int PTR_W = $clog2(DEPTH);

   wbuf_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] tail_ptr;
   logic [CNT_W-1:0] count_reg;

   assign tail_ptr = wr_ptr_reg - PTR_W'(1);

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_entry;
      end else if (merge) begin
         mem[tail_ptr].data <= merge_bytes(mem[tail_ptr].data, wr_entry.data, wr_entry.strb);
         mem[tail_ptr].strb <= mem[tail_ptr].strb | wr_entry.strb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
         else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
      end
   end

   assign head      = mem[rd_ptr_reg];
   assign tail_word = mem[tail_ptr].addr[WB_ADDR_W-1:WORD_ADDR_LSB];
   assign count     = count_reg;

   // A slot is live when its distance from the read pointer is below the count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - rd_ptr_reg;
      assign match[gi] = ({1'b0, age} < count_reg) &&
                         (mem[gi].addr[WB_ADDR_W-1:WORD_ADDR_LSB] == match_word);
   end

endmodule

// File: rtl/dmem_wbuf.sv
// Posted store buffer between the core data port and the data RAM: stores are
// acknowledged on enqueue, drained in order; loads stall on word overlap.
module dmem_wbuf
   import dmem_wbuf_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter int  ADDR_W = WB_ADDR_W,
   parameter int  DATA_W = WB_DATA_W,
   parameter int  MERGE  = 1,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_wready,
   output logic              c_wvalid,
   input  logic [ADDR_W-1:0] c_waddr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [STRB_W-1:0] c_wstrb,
   input  logic              c_rready,
   output logic              c_rvalid,
   input  logic [ADDR_W-1:0] c_raddr,
   output logic              c_rresp,
   output logic [DATA_W-1:0] c_rdata,
   output logic              m_wready,
   input  logic              m_wvalid,
   output logic [ADDR_W-1:0] m_waddr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   output logic              m_rready,
   input  logic              m_rvalid,
   output logic [ADDR_W-1:0] m_raddr,
   input  logic              m_rresp,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              flush_req,
   output logic              flush_done,
   output logic [CNT_W-1:0]  count,
   output logic [15:0]       hazard_cnt
);

   wbuf_entry_t       wr_entry;
   wbuf_entry_t       head;
   logic [WORD_W-1:0] tail_word;
   logic [DEPTH-1:0]  match;
   logic              full;
   logic              merge_ok;
   logic              push;
   logic              merge;
   logic              pop;
   logic              hazard;
   logic              m_wready_reg;
   logic [CNT_W-1:0]  count_next;
   logic [15:0]       hazard_cnt_reg;

   assign wr_entry = '{addr: c_waddr, data: c_wdata, strb: c_wstrb};
   assign full     = (count == CNT_W'(DEPTH));

   // Never merge into the entry the RAM may be sampling right now.
   assign merge_ok = (MERGE != 0) && (count != '0) &&
                     (tail_word == c_waddr[ADDR_W-1:WORD_ADDR_LSB]) &&
                     ((count >= CNT_W'(2)) || !m_wready_reg);

   assign c_wvalid = c_wready && !flush_req && (!full || merge_ok);
   assign merge    = c_wvalid && merge_ok;
   assign push     = c_wvalid && !merge_ok;
   assign pop      = m_wready_reg && m_wvalid;

   dmem_wbuf_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .merge      (merge),
      .wr_entry   (wr_entry),
      .match_word (c_raddr[ADDR_W-1:WORD_ADDR_LSB]),
      .head       (head),
      .tail_word  (tail_word),
      .count      (count),
      .match      (match)
   );

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + CNT_W'(1);
      else if (pop && !push) count_next = count - CNT_W'(1);
   end

   assign hazard = |match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_wready_reg   <= 1'b0;
         hazard_cnt_reg <= '0;
      end else begin
         m_wready_reg <= (count_next != '0);
         if (c_rready && hazard && (hazard_cnt_reg != 16'hFFFF))
            hazard_cnt_reg <= hazard_cnt_reg + 16'd1;
      end
   end

   assign m_wready   = m_wready_reg;
   assign m_waddr    = head.addr;
   assign m_wdata    = head.data;
   assign m_wstrb    = head.strb;
   assign m_rready   = c_rready && !hazard;
   assign m_raddr    = c_raddr;
   assign c_rvalid   = m_rvalid;
   assign c_rresp    = m_rresp;
   assign c_rdata    = m_rdata;
   assign flush_done = flush_req && (count == '0);
   assign hazard_cnt = hazard_cnt_reg;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Scoreboarded bench for dmem_wbuf: a queue of expected RAM writes built from the
// store/merge rules, a write-side monitor, and per-cycle handshake checks.
module tb_dmem_wbuf;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_wready = 1'b0, c_wvalid;
   logic [31:0] c_waddr = '0, c_wdata = '0;
   logic [3:0]  c_wstrb = '0;
   logic        c_rready = 1'b0, c_rvalid, c_rresp;
   logic [31:0] c_raddr = '0, c_rdata;
   logic        m_wready, m_wvalid = 1'b0;
   logic [31:0] m_waddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_rready, m_rvalid = 1'b0, m_rresp = 1'b0;
   logic [31:0] m_raddr, m_rdata = '0;
   logic        flush_req = 1'b0, flush_done;
   logic [2:0]  count;
   logic [15:0] hazard_cnt;

   int          tests = 0;
   int          fails = 0;
   ent_t        expq[$];
   logic [15:0] hcnt = '0;

   dmem_wbuf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .MERGE(1)) dut (
      .clk(clk), .reset(reset),
      .c_wready(c_wready), .c_wvalid(c_wvalid), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
      .c_rready(c_rready), .c_rvalid(c_rvalid), .c_raddr(c_raddr), .c_rresp(c_rresp), .c_rdata(c_rdata),
      .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr), .m_rresp(m_rresp), .m_rdata(m_rdata),
      .flush_req(flush_req), .flush_done(flush_done), .count(count), .hazard_cnt(hazard_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive random RAM read response, check combinational and state
   // outputs mid-cycle against the model, then apply the accepted store.
   task automatic step();
      int   sz;
      logic hz, mok, acc;
      ent_t e;
      m_rvalid = 1'($urandom_range(0, 1));
      m_rresp  = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
      @(negedge clk);
      sz = expq.size();
      hz = 1'b0;
      foreach (expq[i]) if (expq[i].addr[31:2] == c_raddr[31:2]) hz = 1'b1;
      mok = 1'b0;
      if (sz >= 2) mok = (expq[sz-1].addr[31:2] == c_waddr[31:2]);
      acc = c_wready && !flush_req && ((sz < DEPTH) || mok);
      chk("count", 32'(count), 32'(sz));
      chk("m_wready", 32'(m_wready), 32'(sz != 0));
      chk("c_wvalid", 32'(c_wvalid), 32'(acc));
      chk("m_rready", 32'(m_rready), 32'(c_rready && !hz));
      chk("m_raddr", m_raddr, c_raddr);
      chk("flush_done", 32'(flush_done), 32'(flush_req && (sz == 0)));
      chk("hazard_cnt", 32'(hazard_cnt), 32'(hcnt));
      chk("c_rdata", c_rdata, m_rdata);
      chk("c_rvalid_rresp", {30'd0, c_rvalid, c_rresp}, {30'd0, m_rvalid, m_rresp});
      if (acc) begin
         if (mok) begin
            e = expq[sz-1];
            for (int b = 0; b < 4; b++) if (c_wstrb[b]) e.data[8*b +: 8] = c_wdata[8*b +: 8];
            e.strb = e.strb | c_wstrb;
            expq[sz-1] = e;
         end else begin
            expq.push_back('{c_waddr, c_wdata, c_wstrb});
         end
      end
      if (c_rready && hz && (hcnt != 16'hFFFF)) hcnt = hcnt + 16'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      c_wready = 1'b1;
      c_waddr  = a;
      c_wdata  = d;
      c_wstrb  = s;
      step();
      c_wready = 1'b0;
   endtask

   task automatic drain();
      c_wready  = 1'b0;
      c_rready  = 1'b0;
      flush_req = 1'b0;
      m_wvalid  = 1'b1;
      repeat (DEPTH + 2) step();
      m_wvalid  = 1'b0;
   endtask

   // Write-side monitor: every RAM handshake must match the oldest expected store.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!reset && m_wready && m_wvalid) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL ram_write_unexpected: got addr %h expected no write", m_waddr);
            end else begin
               e = expq.pop_front();
               $display("[TB] ram write addr=%h data=%h strb=%h", m_waddr, m_wdata, m_wstrb);
               chk("wr_addr", m_waddr, e.addr);
               chk("wr_data", m_wdata, e.data);
               chk("wr_strb", 32'(m_wstrb), 32'(e.strb));
            end
         end
      end
   end

   initial begin
      #1;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_m_wready", 32'(m_wready), 32'd0);
      chk("reset_hazard_cnt", 32'(hazard_cnt), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();

      // Store burst up to full, then a rejected fifth store, then in-order drain.
      for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), $urandom, 4'hF);
      store(32'h110, 32'h5555_5555, 4'hF);
      drain();

      // Merge into the unissued tail entry.
      store(32'h200, 32'h0000_BBAA, 4'h3);
      store(32'h204, 32'h0000_0011, 4'h1);
      store(32'h204, 32'hDDCC_0000, 4'hC);
      step();
      drain();

      // Load hazard against a queued store, then release by acking the store.
      store(32'h300, 32'hCAFE_F00D, 4'hF);
      c_rready = 1'b1;
      c_raddr  = 32'h302;
      repeat (3) step();
      m_wvalid = 1'b1;
      step();
      m_wvalid = 1'b0;
      repeat (2) step();

      // Non-overlapping load passes straight through.
      store(32'h300, 32'h1234_5678, 4'hF);
      c_rready = 1'b1;
      c_raddr  = 32'h400;
      repeat (2) step();
      drain();

      // Flush: pushes blocked while draining, done once empty.
      for (int i = 0; i < 3; i++) store(32'h500 + 32'(4 * i), $urandom, 4'hF);
      flush_req = 1'b1;
      c_wready  = 1'b1;
      c_waddr   = 32'h520;
      m_wvalid  = 1'b1;
      repeat (5) step();
      drain();

      // Asynchronous reset while entries are pending and a hazard has been counted.
      for (int i = 0; i < 3; i++) store(32'h600 + 32'(4 * i), $urandom, 4'hF);
      c_rready = 1'b1;
      c_raddr  = 32'h604;
      repeat (2) step();
      reset = 1'b1;
      #1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_m_wready", 32'(m_wready), 32'd0);
      chk("midrst_hazard_cnt", 32'(hazard_cnt), 32'd0);
      expq.delete();
      hcnt = '0;
      #1;
      reset = 1'b0;
      c_rready = 1'b0;
      m_wvalid = 1'b1;
      repeat (3) step();
      m_wvalid = 1'b0;

      // Randomized traffic over a few words to exercise merges, hazards and wrap.
      for (int n = 0; n < 400; n++) begin
         c_wready  = 1'($urandom_range(0, 1));
         c_waddr   = 32'h100 + 32'($urandom_range(0, 15));
         c_wdata   = $urandom;
         c_wstrb   = 4'($urandom_range(1, 15));
         c_rready  = 1'($urandom_range(0, 1));
         c_raddr   = 32'h100 + 32'($urandom_range(0, 31));
         m_wvalid  = ((n / 40) % 2 == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
         flush_req = ($urandom_range(0, 15) == 0);
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
